axis_ps_to_pl_packer: RTL and testbench
=======================================

# axis_ps_to_pl_packer

Single-clock AXI-Stream width upsizer that packs 32-bit PS-side words into 128-bit PL-side beats (eight 16-bit samples). It is the return path of the PL-to-PS readout chain: it feeds waveform or control data written by the PS into PL consumers such as the DAC sample buffers. It sits downstream of any PS-domain CDC FIFO, so it sees one clock only. `tlast` closes a partial beat early, with zero padding and a byte-wise `tkeep`.

## Interface
- `IN_WIDTH`, 32: input word width; equals `PS_AXIS_WIDTH`.
- `OUT_WIDTH`, 128: output beat width; equals `PL_AXIS_WIDTH`. `RATIO = OUT_WIDTH/IN_WIDTH` must be a power of two and ≥2.
- `clk` in 1: the single clock for the block.
- `rst` in 1: synchronous reset, active-high.
- `s_axis_tdata` in IN_WIDTH: input word from the PS side.
- `s_axis_tvalid` in 1: input word is valid.
- `s_axis_tready` out 1: block can accept an input word.
- `s_axis_tlast` in 1: last word of a packet; forces the beat to be emitted.
- `m_axis_tdata` out OUT_WIDTH: packed output beat.
- `m_axis_tkeep` out OUT_WIDTH/8: byte enables for the output beat.
- `m_axis_tvalid` out 1: output beat is valid.
- `m_axis_tready` in 1: PL consumer accepts the beat.
- `m_axis_tlast` out 1: beat closes a packet.
- `fill` out log2(RATIO): number of words currently held in the accumulator.

## Operation
- **State:**
  - accumulator `acc[OUT_WIDTH]`, `acc_keep`, fill counter `fill` (0..RATIO-1);
  - output register `out_data`, `out_keep`, `out_last`, `out_valid`.
- **Lane order:** the first accepted word of a beat lands in bits [IN_WIDTH-1:0]. Word k lands in [k*IN_WIDTH +: IN_WIDTH]. This matches the low-lane-first order of the PL-to-PS unpacker.
- **Accept:** `s_axis_tvalid && s_axis_tready`.
- **Beat completion:** an accepted word completes the beat when `fill == RATIO-1` or `s_axis_tlast` is high.
  - On completion, the output register loads `acc` merged with the current word. Unfilled lanes are 0 and their keep bits are 0.
  - `out_last` loads `s_axis_tlast`. `fill` returns to 0 and `acc`/`acc_keep` clear.
- **Non-completing accept:** the word is written to lane `fill`, the 4 keep bits for that lane are set, and `fill` increments.
- **Ready rule:** `s_axis_tready = !m_axis_tvalid || m_axis_tready`, registered-state only.
  - There is no combinational path from `s_axis_tvalid`/`s_axis_tlast` to `s_axis_tready`.
  - The accumulator also stalls while a beat is held, which is intentional.
- **Output:** `m_axis_tvalid = out_valid`.
  - `out_valid` clears on `m_axis_tvalid && m_axis_tready` unless a new completion loads the register in the same cycle. On a same-cycle completion it stays 1 with new contents.
  - `m_axis_tdata`, `m_axis_tkeep` and `m_axis_tlast` are held stable while `m_axis_tvalid && !m_axis_tready`.
- **`tlast` at `fill == 0`:** emits a beat with only lane 0 kept (`tkeep = 16'h000F`).
- **Reset mid-operation:** any partial beat and any held output beat are discarded without being emitted.

## Timing
- Reset values:
  - `m_axis_tvalid = 0`, `m_axis_tdata = 0`, `m_axis_tkeep = 0`, `m_axis_tlast = 0`, `fill = 0`;
  - `s_axis_tready = 1` in the first cycle after reset.
- Latency: a completing word accepted on edge N gives `m_axis_tvalid = 1` after edge N, visible in cycle N+1.
- Throughput with `m_axis_tready = 1`: one input word per cycle, one output beat per RATIO cycles, no bubbles.
- Backpressure: `m_axis_tready = 0` with a beat held drives `s_axis_tready = 0` in the same cycle. Input resumes in the cycle `m_axis_tready` returns to 1.
- Simultaneous drain and completion in one cycle: the new beat is presented in the next cycle with no gap.

## Structure
- `rfsoc_config` holds the constants `PS_AXIS_WIDTH = 32`, `PL_AXIS_WIDTH = 128` and `SAMPLE_WIDTH = 16`.
- Add to `rfsoc_config` a function `lane_keep(fill)` returning the keep mask for a lane index.
- Single module with no sub-module. The output register is inline, not an `axis_sync_fifo`.
- Benches reuse `axis_sync_fifo` as the source and sink models.

## Test plan
- **Full beat:** after reset, send words 0x00001111, 0x22223333, 0x44445555, 0x66667777 back to back with `m_axis_tready = 1`.
  - Expect one beat `128'h66667777_44445555_22223333_00001111`, `tkeep = 16'hFFFF`, `tlast = 0`, `m_axis_tvalid` high in the cycle after the 4th accept.
- **Partial flush:** send 2 words, with `tlast` on the 2nd.
  - Expect upper 64 bits = 0, `tkeep = 16'h00FF`, `tlast = 1`, `fill = 0` afterwards.
- **Backpressure:** 8 words with `m_axis_tready` held 0.
  - Expect 4 words accepted and then `s_axis_tready = 0`.
  - Expect beat 1 held stable for 20 cycles; on release, beat 2 completes and streams with no data loss or reorder.
- **Sustained rate:** 64 words with `m_axis_tready = 1`.
  - Expect 16 beats, `s_axis_tready` never low, and beats on every 4th cycle.
- **Reset mid-operation:** reset after 3 words, then send 4 new words.
  - Expect only the beat made of the 4 new words, and `fill = 0` right after reset.
- **Single-word packet:** `tlast` at `fill == 0` with data 0xDEADBEEF.
  - Expect `m_axis_tdata = 128'h...0000DEADBEEF` (upper lanes 0), `tkeep = 16'h000F`, `tlast = 1`.

Source files
------------

// File: rtl/rfsoc_config.sv
// Shared RFSoC stream widths and keep-mask helper
// for the PS/PL data-mover slice.
package rfsoc_config;

  localparam int PS_AXIS_WIDTH = 32;
  localparam int PL_AXIS_WIDTH = 128;
  localparam int SAMPLE_WIDTH  = 16;

  localparam int PL_KEEP_WIDTH = PL_AXIS_WIDTH / 8;
  localparam int PS_LANE_BYTES = PS_AXIS_WIDTH / 8;

  function automatic logic [PL_KEEP_WIDTH-1:0] lane_keep(
    input int unsigned lane
  );
    logic [PL_KEEP_WIDTH-1:0] one_lane;
    one_lane = '0;
    one_lane[PS_LANE_BYTES-1:0] = '1;
    return one_lane << (lane * PS_LANE_BYTES);
  endfunction

endpackage

// File: rtl/axis_ps_to_pl_packer.sv
// PS-to-PL AXI-Stream upsizer: packs narrow PS words low-lane-first
// into wide PL beats; tlast flushes a partial beat with zero padding.
module axis_ps_to_pl_packer
  import rfsoc_config::*;
#(
  parameter int IN_WIDTH  = PS_AXIS_WIDTH,
  parameter int OUT_WIDTH = PL_AXIS_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [IN_WIDTH-1:0]            s_axis_tdata,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  output logic [OUT_WIDTH-1:0]           m_axis_tdata,
  output logic [OUT_WIDTH/8-1:0]         m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [$clog2(OUT_WIDTH/IN_WIDTH)-1:0] fill
);

  localparam int RATIO  = OUT_WIDTH / IN_WIDTH;
  localparam int FILL_W = $clog2(RATIO);
  localparam int KEEP_W = OUT_WIDTH / 8;
  localparam int LANE_B = IN_WIDTH / 8;

  logic [OUT_WIDTH-1:0] acc;
  logic [KEEP_W-1:0]    acc_keep;
  logic [FILL_W-1:0]    fill_q;

  logic [OUT_WIDTH-1:0] out_data;
  logic [KEEP_W-1:0]    out_keep;
  logic                 out_last;
  logic                 out_valid;

  logic [OUT_WIDTH-1:0] merged_data;
  logic [KEEP_W-1:0]    merged_keep;
  logic                 accept;
  logic                 complete;

  // Ready depends only on registered state and the sink's ready.
  assign s_axis_tready = !out_valid || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign complete      = accept &&
                         (fill_q == FILL_W'(RATIO - 1) || s_axis_tlast);

  always_comb begin
    merged_data = acc;
    merged_keep = acc_keep;
    for (int i = 0; i < RATIO; i++) begin
      if (fill_q == FILL_W'(i)) begin
        merged_data[i*IN_WIDTH +: IN_WIDTH] = s_axis_tdata;
        merged_keep[i*LANE_B +: LANE_B]     = '1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      acc_keep  <= '0;
      fill_q    <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (complete) begin
        out_data  <= merged_data;
        out_keep  <= merged_keep;
        out_last  <= s_axis_tlast;
        out_valid <= 1'b1;
        acc       <= '0;
        acc_keep  <= '0;
        fill_q    <= '0;
      end else begin
        if (accept) begin
          acc      <= merged_data;
          acc_keep <= merged_keep;
          fill_q   <= fill_q + 1'b1;
        end
        if (out_valid && m_axis_tready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

  assign m_axis_tdata  = out_data;
  assign m_axis_tkeep  = out_keep;
  assign m_axis_tlast  = out_last;
  assign m_axis_tvalid = out_valid;
  assign fill          = fill_q;

endmodule

// File: tb/tb_axis_ps_to_pl_packer.sv
// Scoreboard bench for the PS-to-PL packer: a reference packer fills
// a queue on each accepted word; the sink monitor pops and compares.
module tb_axis_ps_to_pl_packer;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b1;
  logic         m_axis_tlast;
  logic [1:0]   fill;

  axis_ps_to_pl_packer dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .fill          (fill)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  int cyc    = 0;
  int pops   = 0;
  int stalls = 0;
  int last_pop = -1;
  bit chk_gap  = 1'b0;

  beat_t sb[$];

  logic [127:0] m_acc  = '0;
  logic [15:0]  m_keep = '0;
  int           m_cnt  = 0;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Sink monitor: every handshake pops one expected beat.
  always @(negedge clk) begin
    if (!rst && m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", 128'(1), 128'(0));
      end else begin
        beat_t e;
        e = sb.pop_front();
        check("beat_data", m_axis_tdata, e.data);
        check("beat_keep", 128'(m_axis_tkeep), 128'(e.keep));
        check("beat_last", 128'(m_axis_tlast), 128'(e.last));
      end
      if (chk_gap && last_pop >= 0)
        check("beat_gap", 128'(cyc - last_pop), 128'(4));
      last_pop = cyc;
      pops++;
    end
  end

  task automatic model_word(input logic [31:0] d, input logic l);
    beat_t b;
    m_acc[m_cnt*32 +: 32] = d;
    m_keep = m_keep | (16'h000F << (4 * m_cnt));
    m_cnt++;
    if (m_cnt == 4 || l) begin
      b.data = m_acc;
      b.keep = m_keep;
      b.last = l;
      sb.push_back(b);
      m_acc  = '0;
      m_keep = '0;
      m_cnt  = 0;
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int waits;
    waits = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (waits != 0) stalls++;
    if (!s_axis_tready) begin
      check("send_timeout", 128'(0), 128'(1));
      s_axis_tvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_word(d, l);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 128'(sb.size()), 128'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_acc = '0; m_keep = '0; m_cnt = 0;
    sb.delete();
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rst_tdata",  m_axis_tdata, 128'(0));
    check("rst_tkeep",  128'(m_axis_tkeep), 128'(0));
    check("rst_tlast",  128'(m_axis_tlast), 128'(0));
    check("rst_fill",   128'(fill), 128'(0));
    check("rst_tready", 128'(s_axis_tready), 128'(1));

    // Full beat
    @(posedge clk); #1;
    send(32'h00001111, 1'b0);
    send(32'h22223333, 1'b0);
    send(32'h44445555, 1'b0);
    send(32'h66667777, 1'b0);
    @(negedge clk);
    check("full_tvalid", 128'(m_axis_tvalid), 128'(1));
    check("full_tdata", m_axis_tdata,
          128'h66667777_44445555_22223333_00001111);
    check("full_tkeep", 128'(m_axis_tkeep), 128'(16'hFFFF));
    check("full_tlast", 128'(m_axis_tlast), 128'(0));
    drain();

    // Partial flush
    @(posedge clk); #1;
    send(32'hA0A0A0A0, 1'b0);
    send(32'hB1B1B1B1, 1'b1);
    @(negedge clk);
    check("part_upper", 128'(m_axis_tdata[127:64]), 128'(0));
    check("part_lower", 128'(m_axis_tdata[63:0]),
          128'(64'hB1B1B1B1_A0A0A0A0));
    check("part_tkeep", 128'(m_axis_tkeep), 128'(16'h00FF));
    check("part_tlast", 128'(m_axis_tlast), 128'(1));
    check("part_fill",  128'(fill), 128'(0));
    drain();

    // Backpressure
    @(posedge clk); #1;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h10000000 + i, 1'b0);
    fork
      begin
        for (int i = 4; i < 8; i++) send(32'h10000000 + i, 1'b0);
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          check("bp_tvalid", 128'(m_axis_tvalid), 128'(1));
          check("bp_tready", 128'(s_axis_tready), 128'(0));
          check("bp_hold", m_axis_tdata,
                128'h10000003_10000002_10000001_10000000);
          check("bp_fill", 128'(fill), 128'(0));
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
      end
    join
    drain();

    // Sustained rate
    @(posedge clk); #1;
    stalls = 0;
    pops = 0;
    last_pop = -1;
    chk_gap = 1'b1;
    for (int i = 0; i < 64; i++) send($urandom, 1'b0);
    drain();
    chk_gap = 1'b0;
    check("rate_beats",  128'(pops), 128'(16));
    check("rate_stalls", 128'(stalls), 128'(0));

    // Reset mid-operation
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) send(32'hBAD00000 + i, 1'b0);
    do_reset();
    @(negedge clk);
    check("mid_rst_fill",   128'(fill), 128'(0));
    check("mid_rst_tvalid", 128'(m_axis_tvalid), 128'(0));
    pops = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(32'hC0DE0000 + i, 1'b0);
    drain();
    check("mid_rst_beats", 128'(pops), 128'(1));

    // Single-word packet
    @(posedge clk); #1;
    send(32'hDEADBEEF, 1'b1);
    @(negedge clk);
    check("single_tdata", m_axis_tdata, 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF);
    check("single_tkeep", 128'(m_axis_tkeep), 128'(16'h000F));
    check("single_tlast", 128'(m_axis_tlast), 128'(1));
    drain();

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
